// File: rtl/tuple_pkg.sv
// tuple_pkg: shared types for the tuple sink.
//   TUPLE_W / BYTE_W : tuple and byte widths
//   tuple_t          : packed tuple {b2, b1, b0}, b0 in the low byte
//   cap_state_e      : capture FSM states
//   cmp_swap         : unsigned compare-swap, returns {max, min}
package tuple_pkg;

    localparam int TUPLE_W = 24;
    localparam int BYTE_W  = 8;

    typedef struct packed {
        logic [BYTE_W-1:0] b2;
        logic [BYTE_W-1:0] b1;
        logic [BYTE_W-1:0] b0;
    } tuple_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } cap_state_e;

    // Ties keep the first operand as the minimum, so equal bytes sort stably.
    function automatic logic [2*BYTE_W-1:0] cmp_swap(input logic [BYTE_W-1:0] a,
                                                     input logic [BYTE_W-1:0] b);
        if (a <= b) begin
            return {b, a};
        end else begin
            return {a, b};
        end
    endfunction

endpackage

// File: rtl/tuple_sink_if.sv
// tuple_sink_if: upstream valid/ack tuple port, downstream valid/ready port
// and status outputs of the tuple sink.
//   master : the environment (upstream search block + host)
//   slave  : the tuple_sink itself
interface tuple_sink_if;
    import tuple_pkg::*;

    logic [TUPLE_W-1:0] tuple;
    logic               valid;
    logic               ack;
    logic [TUPLE_W-1:0] out_tuple;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        tuple_count;
    logic               sum_err;

    modport master (
        output tuple, valid, out_ready,
        input  ack, out_tuple, out_valid, tuple_count, sum_err
    );

    modport slave (
        input  tuple, valid, out_ready,
        output ack, out_tuple, out_valid, tuple_count, sum_err
    );

endinterface

// File: rtl/tuple_fifo.sv
// tuple_fifo: DEPTH-entry FIFO of tuple_t with a registered head.
//   clk, reset            : clock, asynchronous active-low reset
//   i_push, i_data        : write strobe and data (ignored when full and not popping)
//   i_pop                 : remove head (ignored when empty)
//   o_head, o_head_valid  : registered head entry and its valid
//   o_count               : current occupancy, 0..DEPTH
module tuple_fifo
    import tuple_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  tuple_t                  i_data,
    input  logic                    i_pop,
    output tuple_t                  o_head,
    output logic                    o_head_valid,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    tuple_t        r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    tuple_t        r_head;
    logic          r_head_v;

    logic [AW:0]   w_count;
    logic [AW:0]   w_count_after_pop;
    logic [AW:0]   w_count_next;
    logic [AW-1:0] w_rd_next_addr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_bypass;

    // The extra top pointer bit tells full from empty when the address bits match.
    assign w_empty           = (r_wr_ptr == r_rd_ptr);
    assign w_full            = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                               (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_count           = r_wr_ptr - r_rd_ptr;
    assign w_pop             = i_pop & ~w_empty;
    assign w_push            = i_push & (~w_full | w_pop);
    assign w_count_after_pop = w_count - {{AW{1'b0}}, w_pop};
    assign w_count_next      = w_count_after_pop + {{AW{1'b0}}, w_push};
    assign w_rd_next_addr    = r_rd_ptr[AW-1:0] + {{(AW-1){1'b0}}, w_pop};
    // Pushed word becomes the head when nothing older survives this cycle.
    assign w_bypass          = w_push && (w_count_after_pop == {(AW+1){1'b0}});

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointers and registered head; the head holds while nothing is popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
            r_head   <= '{b2: 8'h00, b1: 8'h00, b0: 8'h00};
            r_head_v <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            r_head_v <= (w_count_next != {(AW+1){1'b0}});
            if (w_bypass) begin
                r_head <= i_data;
            end else if (w_count_after_pop != {(AW+1){1'b0}}) begin
                r_head <= r_mem[w_rd_next_addr];
            end
        end
    end

    assign o_head       = r_head;
    assign o_head_valid = r_head_v;
    assign o_count      = w_count;

endmodule

// File: rtl/tuple_sink.sv
// tuple_sink: captures tuples over a valid/ack handshake, sorts the three
// bytes ascending in a two-stage compare-swap pipeline, buffers them in a
// FIFO and drains them over valid/ready. Keeps a saturating capture count.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : tuple_sink_if.slave (tuple/valid/ack upstream,
//                out_tuple/out_valid/out_ready downstream, tuple_count, sum_err)
// Optional feature: define SUM_CHECK_EN to build the byte-sum check against
// TARGET; otherwise sum_err is constant 0.
module tuple_sink
    import tuple_pkg::*;
#(
    parameter int         DEPTH  = 16,
    parameter logic [7:0] TARGET = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    tuple_sink_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    cap_state_e          r_state;
    cap_state_e          w_next_state;
    logic                w_capture;
    logic                r_ack;
    tuple_t              r_cap;
    logic                r_cap_v;
    logic [BYTE_W-1:0]   r_s1_min;
    logic [BYTE_W-1:0]   r_s1_a;
    logic [BYTE_W-1:0]   r_s1_b;
    logic                r_s1_v;
    tuple_t              r_s2;
    logic                r_s2_v;
    logic [15:0]         r_count;
    tuple_t              w_head;
    logic                w_head_v;
    logic [AW:0]         w_fifo_count;
    logic [CW-1:0]       w_used;
    logic                w_credit_ok;
    logic [2*BYTE_W-1:0] w_sw01;
    logic [2*BYTE_W-1:0] w_sw_lo2;
    logic [2*BYTE_W-1:0] w_sw2;

    // Tuples in the sort pipeline already own a FIFO slot.
    assign w_used      = CW'(w_fifo_count) + CW'(r_cap_v) + CW'(r_s1_v) + CW'(r_s2_v);
    assign w_credit_ok = (w_used < CW'(DEPTH));

    // Capture FSM next state; ACK and HOLD always run to completion.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.valid && w_credit_ok) begin
                    w_capture    = 1'b1;
                    w_next_state = ACK;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACK:     w_next_state = HOLD;
            HOLD:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Capture FSM state, ack pulse and saturating tuple counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_count <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_ack   <= w_capture;
            if (w_capture && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'h0001;
            end
        end
    end

    // S1 orders (b0,b1) then (min,b2); S2 orders the two survivors.
    assign w_sw01   = cmp_swap(r_cap.b0, r_cap.b1);
    assign w_sw_lo2 = cmp_swap(w_sw01[BYTE_W-1:0], r_cap.b2);
    assign w_sw2    = cmp_swap(r_s1_a, r_s1_b);

    // Capture register and the two sort stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap    <= '{b2: 8'h00, b1: 8'h00, b0: 8'h00};
            r_cap_v  <= 1'b0;
            r_s1_min <= 8'h00;
            r_s1_a   <= 8'h00;
            r_s1_b   <= 8'h00;
            r_s1_v   <= 1'b0;
            r_s2     <= '{b2: 8'h00, b1: 8'h00, b0: 8'h00};
            r_s2_v   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cap <= bus.tuple;
            end
            r_cap_v  <= w_capture;
            r_s1_min <= w_sw_lo2[BYTE_W-1:0];
            r_s1_a   <= w_sw01[2*BYTE_W-1:BYTE_W];
            r_s1_b   <= w_sw_lo2[2*BYTE_W-1:BYTE_W];
            r_s1_v   <= r_cap_v;
            r_s2     <= '{b2: w_sw2[2*BYTE_W-1:BYTE_W], b1: w_sw2[BYTE_W-1:0], b0: r_s1_min};
            r_s2_v   <= r_s1_v;
        end
    end

    tuple_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (r_s2_v),
        .i_data       (r_s2),
        .i_pop        (w_head_v & bus.out_ready),
        .o_head       (w_head),
        .o_head_valid (w_head_v),
        .o_count      (w_fifo_count)
    );

`ifdef SUM_CHECK_EN
    logic [BYTE_W-1:0] w_sum;
    logic              r_sum_err;

    assign w_sum = r_cap.b0 + r_cap.b1 + r_cap.b2;

    // Sticky sum-check flag, evaluated the cycle after capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum_err <= 1'b0;
        end else if (r_cap_v && (w_sum != TARGET)) begin
            r_sum_err <= 1'b1;
        end
    end

    assign bus.sum_err = r_sum_err;
`else
    // TARGET only matters when the sum check is built.
    logic w_unused_target;
    assign w_unused_target = ^TARGET;
    assign bus.sum_err     = 1'b0;
`endif

    assign bus.ack         = r_ack;
    assign bus.out_tuple   = w_head;
    assign bus.out_valid   = w_head_v;
    assign bus.tuple_count = r_count;

endmodule

// File: tb/tb_tuple_sink.sv
// tb_tuple_sink: directed, table-driven bench for tuple_sink (DEPTH=4).
module tb_tuple_sink;

`ifdef SUM_CHECK_EN
    localparam logic SUM_ON = 1'b1;
`else
    localparam logic SUM_ON = 1'b0;
`endif

    typedef struct {
        logic [23:0] tin;
        logic [23:0] texp;
    } vec_t;

    logic clk;
    logic reset;
    tuple_sink_if bus();

    tuple_sink #(.DEPTH(4), .TARGET(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    logic [23:0] got[$];
    int unsigned ack_cyc[$];
    vec_t        vecs[10];

    // Pops and ack pulses, sampled with pre-edge values.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && bus.out_valid && bus.out_ready) got.push_back(bus.out_tuple);
        if (reset && bus.ack) ack_cyc.push_back(cyc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_tuple(input logic [23:0] t, input int budget, output bit ok);
        ok = 1'b0;
        bus.tuple = t;
        bus.valid = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (got.size() >= n) break;
            @(negedge clk);
        end
        check("pop_count", 32'(got.size()), 32'(n));
    endtask

    task automatic check_order(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) check(name, 32'(got[i]), 32'(vecs[i].texp));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit drv_ok;

        vecs[0] = '{24'h03FEFF, 24'hFFFE03};
        vecs[1] = '{24'h010203, 24'h030201};
        vecs[2] = '{24'h000000, 24'h000000};
        vecs[3] = '{24'hFFFFFF, 24'hFFFFFF};
        vecs[4] = '{24'h807F80, 24'h80807F};
        vecs[5] = '{24'h123456, 24'h563412};
        vecs[6] = '{24'h561234, 24'h563412};
        vecs[7] = '{24'h01FF00, 24'hFF0100};
        vecs[8] = '{24'h050501, 24'h050501};
        vecs[9] = '{24'h7F8001, 24'h807F01};

        reset         = 1'b0;
        bus.valid     = 1'b0;
        bus.tuple     = 24'h000000;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack",       32'(bus.ack),         32'd0);
        check("rst_out_valid", 32'(bus.out_valid),   32'd0);
        check("rst_out_tuple", 32'(bus.out_tuple),   32'd0);
        check("rst_count",     32'(bus.tuple_count), 32'd0);
        check("rst_sum_err",   32'(bus.sum_err),     32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single tuple: one ack pulse, output three cycles after capture.
        bus.tuple     = 24'h03FEFF;
        bus.valid     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t1_ack_hi",  32'(bus.ack),         32'd1);
        check("t1_count",   32'(bus.tuple_count), 32'd1);
        bus.valid = 1'b0;
        @(negedge clk);
        check("t1_ack_lo",  32'(bus.ack),         32'd0);
        @(negedge clk);
        check("t1_early",   32'(bus.out_valid),   32'd0);
        @(negedge clk);
        check("t1_ovalid",  32'(bus.out_valid),   32'd1);
        check("t1_otuple",  32'(bus.out_tuple),   32'hFFFE03);
        repeat (3) @(negedge clk);

        // Table: back-to-back tuples, free-flowing output.
        got.delete();
        ack_cyc.delete();
        drv_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_tuple(vecs[i].tin, 50, ok);
            if (!ok) drv_ok = 1'b0;
        end
        bus.valid = 1'b0;
        check("t2_all_acked", 32'(drv_ok), 32'd1);
        wait_pops(10, 100);
        check_order("t2_out", 10);
        check("t2_ack_count", 32'(ack_cyc.size()), 32'd10);
        for (int i = 1; i < ack_cyc.size(); i++) begin
            check("t2_ack_gap", 32'(ack_cyc[i] - ack_cyc[i-1] >= 3), 32'd1);
        end
        check("t2_count", 32'(bus.tuple_count), 32'd11);

        // Back-pressure: only DEPTH captures, then resume on drain.
        got.delete();
        ack_cyc.delete();
        bus.out_ready = 1'b0;
        drv_ok = 1'b1;
        fork
            begin
                bit dok;
                for (int i = 0; i < 10; i++) begin
                    send_tuple(vecs[i].tin, 200, dok);
                    if (!dok) drv_ok = 1'b0;
                end
                bus.valid = 1'b0;
            end
        join_none
        repeat (40) @(negedge clk);
        check("t3_stall_acks",  32'(ack_cyc.size()), 32'd4);
        check("t3_stall_valid", 32'(bus.valid),      32'd1);
        check("t3_head_valid",  32'(bus.out_valid),  32'd1);
        check("t3_head_stable", 32'(bus.out_tuple),  32'(vecs[0].texp));
        bus.out_ready = 1'b1;
        wait fork;
        check("t3_all_acked", 32'(drv_ok), 32'd1);
        wait_pops(10, 100);
        check_order("t3_out", 10);
        check("t3_count", 32'(bus.tuple_count), 32'd21);

        // Push and pop together at DEPTH-1 entries.
        got.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_tuple(vecs[i].tin, 50, ok);
            check("t4_fill_ack", 32'(ok), 32'd1);
        end
        bus.valid = 1'b0;
        repeat (5) @(negedge clk);
        send_tuple(vecs[3].tin, 50, ok);
        check("t4_ack3", 32'(ok), 32'd1);
        bus.valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t4_pp_valid", 32'(bus.out_valid), 32'd1);
        check("t4_pp_head",  32'(bus.out_tuple), 32'(vecs[1].texp));
        send_tuple(vecs[4].tin, 20, ok);
        check("t4_no_stall", 32'(ok), 32'd1);
        bus.valid = 1'b0;
        repeat (5) @(negedge clk);
        send_tuple(vecs[5].tin, 12, ok);
        check("t4_full_block", 32'(ok), 32'd0);
        bus.out_ready = 1'b1;
        send_tuple(vecs[5].tin, 50, ok);
        check("t4_resume", 32'(ok), 32'd1);
        bus.valid = 1'b0;
        wait_pops(6, 100);
        check_order("t4_out", 6);
        check("t4_count", 32'(bus.tuple_count), 32'd27);

        // Sum check against TARGET=0.
        pulse_reset();
        got.delete();
        send_tuple(24'hFD0201, 50, ok);
        bus.valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_sum_ok",     32'(bus.sum_err), 32'd0);
        send_tuple(24'h030201, 50, ok);
        bus.valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_sum_bad",    32'(bus.sum_err), 32'(SUM_ON));
        send_tuple(24'hFD0201, 50, ok);
        bus.valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_sum_sticky", 32'(bus.sum_err), 32'(SUM_ON));
        check("t5_count",      32'(bus.tuple_count), 32'd3);
        repeat (4) @(negedge clk);

        // Reset during ACK with tuples in flight.
        bus.out_ready = 1'b1;
        send_tuple(vecs[1].tin, 50, ok);
        send_tuple(vecs[2].tin, 50, ok);
        check("t6_in_ack",   32'(bus.ack),       32'd1);
        check("t6_pre_head", 32'(bus.out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_ack",   32'(bus.ack),         32'd0);
        check("t6_rst_valid", 32'(bus.out_valid),   32'd0);
        check("t6_rst_count", 32'(bus.tuple_count), 32'd0);
        got.delete();
        bus.valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_stale",    32'(got.size()),      32'd0);
        check("t6_post_valid",  32'(bus.out_valid),   32'd0);
        check("t6_post_count",  32'(bus.tuple_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tuple_sink.md
# tuple_sink

Downstream stage of the zero-sum tuple search engine. Accepts 24-bit tuples from the search block over its valid/ack handshake. Canonicalises each tuple by sorting its three bytes ascending, then buffers the result in a FIFO. Drains the FIFO to the host side over a valid/ready interface and keeps a running tuple count.

## Interface
- DEPTH, 16: FIFO entries; power of two, 4..256
- TARGET, 8'h00: expected byte-sum of every tuple; used only when the sum check is compiled in
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; all state is cleared while low
- tuple  in  24  upstream tuple; byte 0 = [7:0], byte 1 = [15:8], byte 2 = [23:16]
- valid  in  1  upstream tuple valid; upstream holds `tuple` stable until it samples `ack`
- ack  out  1  one-cycle capture pulse to upstream
- out_tuple  out  24  sorted tuple, min in [7:0], max in [23:16]
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head when high with out_valid
- tuple_count  out  16  tuples accepted since reset; saturates at 16'hFFFF
- sum_err  out  1  sticky sum-check failure flag

## Operation
- Capture FSM, three states:
  - IDLE: when valid=1 and credit>0, register `tuple`, drive ack=1 next cycle, go to ACK.
  - ACK: ack=1 for exactly this cycle, go to HOLD.
  - HOLD: ack=0 for one cycle so upstream can update `tuple`, go to IDLE.
- Because upstream updates on the edge after it sees ack, a tuple is never captured twice. The maximum capture rate is one tuple per 3 cycles.
- Credit = DEPTH − fifo_count − tuples in the sort pipeline. Capture only when credit>0. The FIFO can never overflow and no tuple is dropped.
- Sort pipeline, 2 registered stages of unsigned compare-swap:
  - S1: order (b0,b1), then (min,b2).
  - S2: order the remaining pair.
  - The result is written to the FIFO tail at the S2 output.
- FIFO: registered head.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both honoured and fifo_count is unchanged.
  - A push into an empty FIFO appears on out_tuple the next cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally; full/empty are resolved with an extra wrap bit.
- tuple_count increments at capture (the IDLE→ACK edge) and saturates.
- Equal bytes sort stably; any order of equal values is correct output.

## Timing
- Reset values: ack=0, out_valid=0, out_tuple=0, tuple_count=0, sum_err=0, FSM=IDLE, FIFO empty, pipeline valids 0.
- Latency from the capture edge to out_valid with an empty FIFO: 3 cycles (capture reg, S1, S2/push, head visible).
- Reset asserted mid-operation: everything clears asynchronously, in-flight tuples are discarded, and ack drops immediately.
- After reset deasserts, the first capture needs valid=1 seen at a rising edge.
- If valid falls while in ACK or HOLD, the FSM completes the sequence and returns to IDLE.
- out_tuple is stable while out_valid=1 and out_ready=0.

## Configuration
- SUM_CHECK_EN defined:
  - At capture, the block computes (b0+b1+b2) mod 256 in 8-bit wrap arithmetic.
  - On mismatch with TARGET, sum_err sets on the following edge and stays set until reset.
  - The tuple is still forwarded.
- SUM_CHECK_EN undefined: sum_err is tied to 0 and no adder logic is built. The port exists in both builds.

## Structure
- Package tuple_pkg holds:
  - TUPLE_W=24 and BYTE_W=8
  - packed struct tuple_t {b2,b1,b0}
  - capture FSM state enum {IDLE, ACK, HOLD}
- Sub-module tuple_fifo: parameterised DEPTH storage of tuple_t, push/pop/count, registered head. The capture FSM, sort pipeline and checks stay in tuple_sink.

## Test plan
- Reset, then valid=1 with tuple=24'h03_FE_FF (b0=FF, b1=FE, b2=03), out_ready=1 -> one ack pulse; out_tuple=24'hFF_FE_03 three cycles after capture; tuple_count=1.
- Upstream presents 5 tuples back-to-back, each held until ack -> exactly 5 acks spaced at least 3 cycles apart; 5 outputs in order; no duplicates.
- out_ready=0, DEPTH=4, 10 tuples offered -> exactly 4 acks, then valid stays high with no ack. Raising out_ready drains and resumes capture; all 10 are delivered in order.
- Simultaneous push and pop with FIFO at DEPTH−1 entries -> count unchanged, no stall, order preserved across pointer wrap.
- SUM_CHECK_EN with TARGET=0: tuple 01,02,FD -> sum_err stays 0. Tuple 01,02,03 -> sum_err=1 and remains 1. Without the macro the same stimulus leaves sum_err=0.
- Reset pulsed low while in ACK with 2 tuples in the pipeline -> ack, out_valid and tuple_count are 0 immediately. Nothing stale emerges after release.
